// File: rtl/rob_cmt.sv
// In-order commit buffer: allocates tags at dispatch, collects out-of-order
// write-back results by tag and retires them to the GPR port in program order.
module rob_cmt #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              disp_vld,
    output logic              disp_rdy,
    input  logic [4:0]        disp_rd,
    input  logic              disp_wen,
    output logic [IDX_W-1:0]  disp_tag,
    input  logic              wb_mul_vld,
    input  logic [IDX_W-1:0]  wb_mul_tag,
    input  logic [DATA_W-1:0] wb_mul_wdata,
    input  logic              wb_div_vld,
    input  logic [IDX_W-1:0]  wb_div_tag,
    input  logic [DATA_W-1:0] wb_div_wdata,
    input  logic              wb_lsu_vld,
    input  logic [IDX_W-1:0]  wb_lsu_tag,
    input  logic [DATA_W-1:0] wb_lsu_wdata,
    input  logic              wb_alu_vld,
    input  logic [IDX_W-1:0]  wb_alu_tag,
    input  logic [DATA_W-1:0] wb_alu_wdata,
    output logic              cmt_vld,
    output logic              cmt_wen,
    output logic [4:0]        cmt_rd,
    output logic [DATA_W-1:0] cmt_wdata,
    output logic [IDX_W:0]    cnt,
    output logic              empty,
    output logic              full
);

    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [IDX_W:0]    head_q, head_d;
    logic [IDX_W:0]    tail_q, tail_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  wen_q, wen_d;
    logic [4:0]        rd_q [DEPTH];
    logic [4:0]        rd_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;
    logic              disp_acc;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    // The wrap bit distinguishes full from empty when the indices coincide.
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign cnt      = tail_q - head_q;
    assign disp_rdy = !full;
    assign disp_tag = tail_idx;
    assign disp_acc = disp_vld && !full;

    always_comb begin
        cmt_vld   = valid_q[head_idx] && done_q[head_idx] && !flush;
        cmt_wen   = cmt_vld && wen_q[head_idx];
        cmt_rd    = cmt_vld ? rd_q[head_idx] : 5'd0;
        cmt_wdata = cmt_vld ? data_q[head_idx] : '0;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        wen_d   = wen_q;
        rd_d    = rd_q;
        data_d  = data_q;

        // Only pending entries accept a result; the if-chain gives mul > div > lsu > alu.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !done_q[i]) begin
                if (wb_mul_vld && wb_mul_tag == IDX_W'(i)) begin
                    done_d[i] = 1'b1;
                    data_d[i] = wb_mul_wdata;
                end else if (wb_div_vld && wb_div_tag == IDX_W'(i)) begin
                    done_d[i] = 1'b1;
                    data_d[i] = wb_div_wdata;
                end else if (wb_lsu_vld && wb_lsu_tag == IDX_W'(i)) begin
                    done_d[i] = 1'b1;
                    data_d[i] = wb_lsu_wdata;
                end else if (wb_alu_vld && wb_alu_tag == IDX_W'(i)) begin
                    done_d[i] = 1'b1;
                    data_d[i] = wb_alu_wdata;
                end
            end
        end

        if (cmt_vld) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + PTR_ONE;
        end

        if (disp_acc) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            rd_d[tail_idx]    = disp_rd;
            wen_d[tail_idx]   = disp_wen && (disp_rd != 5'd0);
            tail_d            = tail_q + PTR_ONE;
        end

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            wen_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_rob_cmt.sv
// Self-checking bench for rob_cmt: directed scenarios plus a randomized run
// compared against a program-order queue model of the buffer.
module tb_rob_cmt;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 64;

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              disp_vld;
    logic              disp_rdy;
    logic [4:0]        disp_rd;
    logic              disp_wen;
    logic [IDX_W-1:0]  disp_tag;
    logic              wb_mul_vld, wb_div_vld, wb_lsu_vld, wb_alu_vld;
    logic [IDX_W-1:0]  wb_mul_tag, wb_div_tag, wb_lsu_tag, wb_alu_tag;
    logic [DATA_W-1:0] wb_mul_wdata, wb_div_wdata, wb_lsu_wdata, wb_alu_wdata;
    logic              cmt_vld, cmt_wen;
    logic [4:0]        cmt_rd;
    logic [DATA_W-1:0] cmt_wdata;
    logic [IDX_W:0]    cnt;
    logic              empty, full;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          wen;
        bit          done;
        logic [63:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_tail_tag;

    rob_cmt #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_rd(disp_rd),
        .disp_wen(disp_wen), .disp_tag(disp_tag),
        .wb_mul_vld(wb_mul_vld), .wb_mul_tag(wb_mul_tag), .wb_mul_wdata(wb_mul_wdata),
        .wb_div_vld(wb_div_vld), .wb_div_tag(wb_div_tag), .wb_div_wdata(wb_div_wdata),
        .wb_lsu_vld(wb_lsu_vld), .wb_lsu_tag(wb_lsu_tag), .wb_lsu_wdata(wb_lsu_wdata),
        .wb_alu_vld(wb_alu_vld), .wb_alu_tag(wb_alu_tag), .wb_alu_wdata(wb_alu_wdata),
        .cmt_vld(cmt_vld), .cmt_wen(cmt_wen), .cmt_rd(cmt_rd), .cmt_wdata(cmt_wdata),
        .cnt(cnt), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        flush = 0; disp_vld = 0; disp_rd = 0; disp_wen = 0;
        wb_mul_vld = 0; wb_mul_tag = 0; wb_mul_wdata = 0;
        wb_div_vld = 0; wb_div_tag = 0; wb_div_wdata = 0;
        wb_lsu_vld = 0; wb_lsu_tag = 0; wb_lsu_wdata = 0;
        wb_alu_vld = 0; wb_alu_tag = 0; wb_alu_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 0;
        clear_inputs();
        next_cycle();
        rstn = 1;
    endtask

    task automatic set_wb(input int p, input int t, input logic [63:0] d);
        case (p)
            0: begin wb_mul_vld = 1; wb_mul_tag = 3'(t); wb_mul_wdata = d; end
            1: begin wb_div_vld = 1; wb_div_tag = 3'(t); wb_div_wdata = d; end
            2: begin wb_lsu_vld = 1; wb_lsu_tag = 3'(t); wb_lsu_wdata = d; end
            default: begin wb_alu_vld = 1; wb_alu_tag = 3'(t); wb_alu_wdata = d; end
        endcase
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic wen);
        disp_vld = 1; disp_rd = rd; disp_wen = wen;
    endtask

    task automatic test_reset();
        rstn = 0;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        n_checks++; if ({empty, full, disp_rdy} !== 3'b101) begin n_fail++; $display("FAIL reset_flags got empty/full/rdy=%b exp=101", {empty, full, disp_rdy}); end
        n_checks++; if (disp_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag got=%0d exp=0", disp_tag); end
        n_checks++; if ({cmt_vld, cmt_wen, cmt_rd, cmt_wdata} !== 71'd0) begin n_fail++; $display("FAIL reset_cmt got vld=%b wen=%b rd=%0d data=%h exp all 0", cmt_vld, cmt_wen, cmt_rd, cmt_wdata); end
        next_cycle();
        rstn = 1;
    endtask

    task automatic test_inorder();
        logic [63:0] exp_d [3];
        exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dispatch(5'(i + 1), 1'b1);
            @(negedge clk);
            n_checks++; if (disp_tag !== 3'(i)) begin n_fail++; $display("FAIL inorder_tag got=%0d exp=%0d", disp_tag, i); end
            next_cycle();
        end
        clear_inputs();
        set_wb(3, 2, 64'h33);
        @(negedge clk);
        n_checks++; if (cnt !== 4'd3) begin n_fail++; $display("FAIL inorder_cnt got=%0d exp=3", cnt); end
        n_checks++; if (cmt_vld !== 1'b0) begin n_fail++; $display("FAIL inorder_early_cmt got=%b exp=0", cmt_vld); end
        next_cycle(); clear_inputs();
        set_wb(0, 0, 64'h11);
        @(negedge clk);
        n_checks++; if (cmt_vld !== 1'b0) begin n_fail++; $display("FAIL inorder_out_of_order_cmt got=%b exp=0", cmt_vld); end
        next_cycle(); clear_inputs();
        set_wb(1, 1, 64'h22);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if ({cmt_vld, cmt_wen, cmt_rd, cmt_wdata} !== {1'b1, 1'b1, 5'(k + 1), exp_d[k]}) begin n_fail++; $display("FAIL inorder_commit%0d got vld=%b wen=%b rd=%0d data=%h exp rd=%0d data=%h", k, cmt_vld, cmt_wen, cmt_rd, cmt_wdata, k + 1, exp_d[k]); end
            next_cycle(); clear_inputs();
        end
        @(negedge clk);
        n_checks++; if ({cmt_vld, empty} !== 2'b01) begin n_fail++; $display("FAIL inorder_drained got vld/empty=%b exp=01", {cmt_vld, empty}); end
        next_cycle();
    endtask

    task automatic test_full_wrap();
        int          t;
        logic [4:0]  erd;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            dispatch(5'(i + 1), 1'b1);
            next_cycle();
        end
        dispatch(5'd9, 1'b1);
        @(negedge clk);
        n_checks++; if ({full, disp_rdy, cnt} !== {1'b1, 1'b0, 4'd8}) begin n_fail++; $display("FAIL full_flags got full=%b rdy=%b cnt=%0d exp 1/0/8", full, disp_rdy, cnt); end
        next_cycle();
        set_wb(2, 0, 64'h77);
        @(negedge clk);
        n_checks++; if ({cnt, cmt_vld} !== {4'd8, 1'b0}) begin n_fail++; $display("FAIL full_drop got cnt=%0d vld=%b exp 8/0", cnt, cmt_vld); end
        next_cycle(); clear_inputs();
        dispatch(5'd9, 1'b1);
        @(negedge clk);
        n_checks++; if ({cmt_vld, cmt_rd, cmt_wdata} !== {1'b1, 5'd1, 64'h77}) begin n_fail++; $display("FAIL full_commit got vld=%b rd=%0d data=%h exp 1/1/77", cmt_vld, cmt_rd, cmt_wdata); end
        n_checks++; if (disp_rdy !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass got rdy=%b exp=0", disp_rdy); end
        next_cycle();
        dispatch(5'd10, 1'b1);
        @(negedge clk);
        n_checks++; if ({cnt, disp_rdy, disp_tag} !== {4'd7, 1'b1, 3'd0}) begin n_fail++; $display("FAIL wrap_accept got cnt=%0d rdy=%b tag=%0d exp 7/1/0", cnt, disp_rdy, disp_tag); end
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_checks++; if ({cnt, full} !== {4'd8, 1'b1}) begin n_fail++; $display("FAIL wrap_full got cnt=%0d full=%b exp 8/1", cnt, full); end
        for (int p = 0; p < 4; p++) set_wb(p, p + 1, 64'h100 + 64'(p + 1));
        next_cycle(); clear_inputs();
        for (int p = 0; p < 4; p++) set_wb(p, (p + 5) % DEPTH, 64'h100 + 64'((p + 5) % DEPTH));
        for (int k = 0; k < DEPTH; k++) begin
            t   = (k + 1) % DEPTH;
            erd = (t == 0) ? 5'd10 : 5'(t + 1);
            @(negedge clk);
            n_checks++; if ({cmt_vld, cmt_rd, cmt_wdata} !== {1'b1, erd, 64'h100 + 64'(t)}) begin n_fail++; $display("FAIL wrap_drain%0d got vld=%b rd=%0d data=%h exp rd=%0d data=%h", k, cmt_vld, cmt_rd, cmt_wdata, erd, 64'h100 + 64'(t)); end
            next_cycle(); clear_inputs();
        end
        @(negedge clk);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got=%b exp=1", empty); end
        next_cycle();
    endtask

    task automatic test_same_tag();
        logic [63:0] ed;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch(5'(11 + i), 1'b1);
            next_cycle();
        end
        clear_inputs();
        set_wb(0, 3, 64'hAA);
        set_wb(3, 3, 64'hBB);
        next_cycle(); clear_inputs();
        set_wb(1, 3, 64'hEE);
        set_wb(0, 0, 64'h1);
        set_wb(2, 1, 64'h2);
        set_wb(3, 2, 64'h3);
        next_cycle(); clear_inputs();
        for (int k = 0; k < 4; k++) begin
            ed = (k == 3) ? 64'hAA : 64'(k + 1);
            @(negedge clk);
            n_checks++; if ({cmt_vld, cmt_rd, cmt_wdata} !== {1'b1, 5'(11 + k), ed}) begin n_fail++; $display("FAIL same_tag_commit%0d got vld=%b rd=%0d data=%h exp rd=%0d data=%h", k, cmt_vld, cmt_rd, cmt_wdata, 11 + k, ed); end
            next_cycle();
        end
    endtask

    task automatic test_rd0();
        do_reset();
        dispatch(5'd0, 1'b1);
        next_cycle();
        dispatch(5'd4, 1'b0);
        next_cycle(); clear_inputs();
        set_wb(3, 0, 64'h5);
        set_wb(2, 1, 64'h6);
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_checks++; if ({cmt_vld, cmt_wen, cmt_rd, cmt_wdata} !== {1'b1, 1'b0, 5'd0, 64'h5}) begin n_fail++; $display("FAIL rd0_commit got vld=%b wen=%b rd=%0d data=%h exp 1/0/0/5", cmt_vld, cmt_wen, cmt_rd, cmt_wdata); end
        next_cycle();
        @(negedge clk);
        n_checks++; if ({cmt_vld, cmt_wen, cmt_rd, cmt_wdata} !== {1'b1, 1'b0, 5'd4, 64'h6}) begin n_fail++; $display("FAIL nowen_commit got vld=%b wen=%b rd=%0d data=%h exp 1/0/4/6", cmt_vld, cmt_wen, cmt_rd, cmt_wdata); end
        next_cycle();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            dispatch(5'(i + 1), 1'b1);
            next_cycle();
        end
        clear_inputs();
        set_wb(0, 0, 64'h99);
        next_cycle(); clear_inputs();
        flush = 1;
        dispatch(5'd20, 1'b1);
        set_wb(3, 1, 64'h55);
        @(negedge clk);
        n_checks++; if (cmt_vld !== 1'b0) begin n_fail++; $display("FAIL flush_cmt_forced got=%b exp=0", cmt_vld); end
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_checks++; if ({cnt, empty, cmt_vld, disp_tag} !== {4'd0, 1'b1, 1'b0, 3'd0}) begin n_fail++; $display("FAIL flush_state got cnt=%0d empty=%b vld=%b tag=%0d exp 0/1/0/0", cnt, empty, cmt_vld, disp_tag); end
        next_cycle();
        dispatch(5'd7, 1'b1);
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_checks++; if ({cnt, cmt_vld} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL flush_stale_done got cnt=%0d vld=%b exp 1/0", cnt, cmt_vld); end
        set_wb(3, 0, 64'h8);
        next_cycle(); clear_inputs();
        @(negedge clk);
        n_checks++; if ({cmt_vld, cmt_wen, cmt_rd, cmt_wdata} !== {1'b1, 1'b1, 5'd7, 64'h8}) begin n_fail++; $display("FAIL flush_after_commit got vld=%b wen=%b rd=%0d data=%h exp 1/1/7/8", cmt_vld, cmt_wen, cmt_rd, cmt_wdata); end
        next_cycle();
    endtask

    task automatic test_random(input int ncyc);
        bit          vld [4];
        int          tag [4];
        logic [63:0] dat [4];
        bit          exp_vld, acc;
        ent_t        e;
        logic [70:0] exp_cmt;
        do_reset();
        mq.delete();
        m_tail_tag = 0;
        for (int c = 0; c < ncyc; c++) begin
            clear_inputs();
            rstn     = ($urandom_range(0, 99) != 0);
            flush    = ($urandom_range(0, 47) == 0);
            disp_vld = ($urandom_range(0, 9) < 6);
            disp_rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            disp_wen = $urandom_range(0, 1) == 1;
            for (int p = 0; p < 4; p++) begin
                vld[p] = ($urandom_range(0, 9) < 4);
                tag[p] = $urandom_range(0, DEPTH - 1);
                dat[p] = {$urandom, $urandom};
                if (vld[p]) set_wb(p, tag[p], dat[p]);
            end
            exp_vld = (mq.size() > 0) && mq[0].done && !flush;
            exp_cmt = exp_vld ? {1'b1, mq[0].wen, mq[0].rd, mq[0].data} : 71'd0;
            @(negedge clk);
            n_checks++; if (cnt !== 4'(mq.size())) begin n_fail++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, cnt, mq.size()); end
            n_checks++; if ({empty, full, disp_rdy} !== {mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH}) begin n_fail++; $display("FAIL rand_flags cyc=%0d got empty/full/rdy=%b size=%0d", c, {empty, full, disp_rdy}, mq.size()); end
            n_checks++; if (disp_tag !== 3'(m_tail_tag)) begin n_fail++; $display("FAIL rand_tag cyc=%0d got=%0d exp=%0d", c, disp_tag, m_tail_tag); end
            n_checks++; if ({cmt_vld, cmt_wen, cmt_rd, cmt_wdata} !== exp_cmt) begin n_fail++; $display("FAIL rand_cmt cyc=%0d got=%h exp=%h", c, {cmt_vld, cmt_wen, cmt_rd, cmt_wdata}, exp_cmt); end
            // reference model update for this clock edge
            acc = disp_vld && (mq.size() < DEPTH);
            for (int p = 0; p < 4; p++) begin
                if (vld[p]) begin
                    for (int j = 0; j < mq.size(); j++) begin
                        if (mq[j].tag == tag[p] && !mq[j].done) begin
                            e = mq[j]; e.done = 1; e.data = dat[p]; mq[j] = e;
                        end
                    end
                end
            end
            if (exp_vld) void'(mq.pop_front());
            if (acc) begin
                e.tag = m_tail_tag; e.rd = disp_rd; e.wen = disp_wen && (disp_rd != 0);
                e.done = 0; e.data = 0;
                mq.push_back(e);
                m_tail_tag = (m_tail_tag + 1) % DEPTH;
            end
            if (!rstn || flush) begin
                mq.delete();
                m_tail_tag = 0;
            end
            next_cycle();
        end
        rstn = 1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rstn = 0;
        next_cycle();
        test_reset();
        test_inorder();
        test_full_wrap();
        test_same_tag();
        test_rd0();
        test_flush();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_cmt.md
Name: rob_cmt

Overview:
In-order commit buffer (reorder buffer) sitting downstream of the write-back arbiter.
- Dispatch allocates one entry per instruction and receives a tag.
- ALU/MUL/DIV/LSU write-back ports return results by tag, out of order.
- The block retires results strictly in program order to the GPR write port, one per cycle.
- It is the consumer end of the per-unit write-back valid/data interface.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2
IDX_W, 3, log2(DEPTH); tag width
DATA_W, 64, result data width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush  in  1  discard all entries (pipeline flush)
disp_vld  in  1  dispatch request
disp_rdy  out  1  entry available (= !full)
disp_rd  in  5  destination register index
disp_wen  in  1  instruction writes a GPR
disp_tag  out  IDX_W  tag assigned on accept (= tail index)
wb_mul_vld / wb_div_vld / wb_lsu_vld / wb_alu_vld  in  1 each  result valid, per unit
wb_mul_tag / wb_div_tag / wb_lsu_tag / wb_alu_tag  in  IDX_W each  target entry, per unit
wb_mul_wdata / wb_div_wdata / wb_lsu_wdata / wb_alu_wdata  in  DATA_W each  result, per unit
cmt_vld  out  1  head entry retires this cycle
cmt_wen  out  1  GPR write enable
cmt_rd  out  5  GPR index
cmt_wdata  out  DATA_W  GPR data
cnt  out  IDX_W+1  occupied entries
empty  out  1  cnt == 0
full  out  1  cnt == DEPTH

Behaviour:
- Storage per entry: valid, done, rd, wen, data.
- Pointers: head and tail, each IDX_W+1 bits including a wrap bit.
  - empty when head == tail.
  - full when the index bits are equal and the wrap bits differ.
- Reset (rstn=0 at posedge):
  - all valid/done bits cleared; head = tail = 0.
  - resulting outputs: cnt=0, empty=1, full=0, disp_rdy=1, disp_tag=0, cmt_vld=0, cmt_wen=0, cmt_rd=0, cmt_wdata=0.
  - Reset mid-operation discards all in-flight entries.
- Dispatch:
  - Accepted on disp_vld && disp_rdy.
  - Writes valid=1, done=0, rd, and wen=(disp_wen && disp_rd!=0); tail increments.
  - disp_tag is combinational from tail and is meaningful in the accept cycle.
  - When full, disp_rdy=0 even if a commit happens in the same cycle; there is no bypass.
- Write-back:
  - Any wb_*_vld whose tag points to an entry with valid=1 && done=0 sets done=1 and stores the data at the clock edge.
  - Write-back to an invalid or already-done entry is ignored.
  - Up to four distinct tags may complete in one cycle.
  - If two or more ports target the same tag, the data taken follows priority mul > div > lsu > alu; done is set once.
- Commit (combinational from registered state):
  - cmt_vld = head entry valid && done && !flush.
  - cmt_wen = cmt_vld && entry.wen; cmt_rd/cmt_wdata come from the head entry, and are 0 when cmt_vld=0.
  - On cmt_vld the entry is cleared and head increments; at most one retire per cycle.
  - A write-back that completes the head entry is retired the following cycle (one-cycle minimum write-back-to-commit latency).
- Simultaneous events:
  - Dispatch and commit in the same cycle: cnt unchanged, both pointers advance.
  - Dispatch into an index being freed by commit in the same cycle is impossible because the full rule prevents it.
- Pointer wrap: head and tail wrap modulo 2*DEPTH via the wrap bit; tags wrap modulo DEPTH.
- Flush:
  - Highest priority: at the clock edge all valid/done bits are cleared and head = tail = 0.
  - Dispatch, write-back and commit in the flush cycle are discarded; cmt_vld is forced 0 during that cycle.
- cnt = tail - head in IDX_W+1-bit arithmetic.

Test Plan:
- Reset, then dispatch 3 instructions (rd=1,2,3, wen=1) -> tags 0,1,2; cnt=3; no commit before any write-back.
- Write-back in order alu tag2=0x33, mul tag0=0x11, div tag1=0x22, one per cycle -> commits rd1=0x11, rd2=0x22, rd3=0x33 on consecutive cycles, in order; the first commit occurs the cycle after tag0 completes.
- Fill 8 entries -> full=1, disp_rdy=0; a dispatch attempt is dropped; complete tag0 -> one commit; next cycle disp_rdy=1 and a new dispatch receives tag0 with wrap bit set.
- Same-cycle mul and alu write-back to tag3 with data 0xAA and 0xBB -> the entry holds 0xAA.
- Dispatch with rd=0, wen=1, then complete it with data 0x5 -> cmt_vld=1, cmt_wen=0.
- Flush with 5 entries live and a simultaneous dispatch and write-back -> next cycle cnt=0, empty=1, cmt_vld=0; the next dispatch receives tag0.
